// File: rtl/sr_conv_pkg.sv
// Shared types and the round-half-to-even / saturate helper used by the
// spatial-reduction convolution blocks.
package sr_conv_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 40;

  // Working width of round_sat; any accumulator up to this width fits.
  localparam int RS_W = 64;

  typedef struct packed {
    logic [31:0] ch, tap, col, row;
  } cnt_t;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } rs_t;

  function automatic rs_t round_sat(input logic signed [RS_W-1:0] full,
                                    input int frac_w, input int data_w);
    logic signed [RS_W-1:0] q, hi, lo, half, mask;
    rs_t r;
    half = 64'sd1 <<< (frac_w - 1);
    mask = half - 64'sd1;
    q    = full >>> frac_w;
    if (((full & half) != '0) && (((full & mask) != '0) || q[0]))
      q = q + 64'sd1;
    hi    = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (data_w - 1));
    r.sat = (q > hi) || (q < lo);
    r.val = (q > hi) ? hi : ((q < lo) ? lo : q);
    return r;
  endfunction

endpackage

// File: rtl/sr_conv_channel_p_round_sat.sv
// Output stage: rounds and saturates the accumulated result and registers
// the channel outputs.
module sr_round_sat
  import sr_conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid,
  input  logic                     last,
  input  logic signed [ACC_W-1:0]  full,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     out_sat
);

  rs_t rs;

  always_comb rs = round_sat(RS_W'(full), FRAC_W, DATA_W);

  // S4: registered outputs; data holds between result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= valid;
      out_last  <= valid && last;
      out_sat   <= valid && rs.sat;
      if (valid) out_data <= DATA_W'(rs.val);
    end
  end

endmodule

// File: rtl/sr_conv_channel_p.sv
// Spatial-reduction convolution accumulator for one output channel: streams
// activation/weight beats, carries per-column partial sums across kernel rows.
module sr_conv_channel_p
  import sr_conv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CH       = 64,
  parameter int KW       = 8,
  parameter int KH       = 8,
  parameter int OUT_COLS = 22
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     out_sat
);

  localparam int CW    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int DEPTH = 1 << CW;
  localparam int PW    = 2 * DATA_W;

  cnt_t cnt;
  logic take, ch_end, tap_end, col_end, row_end;

  logic signed [DATA_W-1:0] x_p1, w_p1, bias_p1, bias_p2;
  logic [CW-1:0]            col_p1, col_p2;
  logic                     first_p1, last_p1, final_p1;
  logic                     first_p2, last_p2, final_p2;
  logic                     vld_p1, vld_p2, vld_p3, lcol_p3;
  logic signed [PW-1:0]     prod_p2;
  logic signed [ACC_W-1:0]  base_p2, sum_p2, acc_p3, full_p3;
  logic signed [ACC_W-1:0]  col_buf [DEPTH];

  assign take    = in_valid && !clear;
  assign ch_end  = cnt.ch  == 32'(CH - 1);
  assign tap_end = cnt.tap == 32'(KW - 1);
  assign col_end = cnt.col == 32'(OUT_COLS - 1);
  assign row_end = cnt.row == 32'(KH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt.ch <= ch_end ? '0 : cnt.ch + 32'd1;
      if (ch_end) begin
        cnt.tap <= tap_end ? '0 : cnt.tap + 32'd1;
        if (tap_end) begin
          cnt.col <= col_end ? '0 : cnt.col + 32'd1;
          if (col_end) cnt.row <= row_end ? '0 : cnt.row + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= take;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2 && final_p2;
    end
  end

  // S1: operands and position tags
  always_ff @(posedge clk) begin
    if (take) begin
      x_p1     <= in_data;
      w_p1     <= weight;
      bias_p1  <= bias;
      col_p1   <= cnt.col[CW-1:0];
      first_p1 <= (cnt.ch == '0) && (cnt.tap == '0);
      last_p1  <= ch_end && tap_end;
      final_p1 <= ch_end && tap_end && row_end;
    end
  end

  // S2: full-precision signed product
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      prod_p2  <= PW'(x_p1) * PW'(w_p1);
      bias_p2  <= bias_p1;
      col_p2   <= col_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      final_p2 <= final_p1;
    end
  end

  // S3: the buffer is read and rewritten in this same cycle, so a column
  // revisited on the very next beat already sees the updated partial sum.
  always_comb begin
    base_p2 = first_p2 ? col_buf[col_p2] : acc_p3;
    sum_p2  = base_p2 + ACC_W'(prod_p2);
  end

  always_ff @(posedge clk) begin
    if (vld_p2) acc_p3 <= sum_p2;
    if (vld_p2 && final_p2) begin
      full_p3 <= sum_p2 + (ACC_W'(bias_p2) <<< FRAC_W);
      lcol_p3 <= col_p2 == CW'(OUT_COLS - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) col_buf[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) col_buf[i] <= '0;
    end else if (vld_p2 && last_p2) begin
      col_buf[col_p2] <= final_p2 ? '0 : sum_p2;
    end
  end

  sr_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_round_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .valid     (vld_p3),
    .last      (lcol_p3),
    .full      (full_p3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

endmodule

// File: tb/tb_sr_conv_channel_p.sv
// Scoreboard bench for sr_conv_channel_p: a 3-column instance and a
// single-column instance, directed frames with hand-computed results.
module tb_sr_conv_channel_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic signed [15:0] in_data = '0, weight = '0, bias = '0;
  logic signed [15:0] out_data_a, out_data_b;
  logic out_valid_a, out_last_a, out_sat_a;
  logic out_valid_b, out_last_b, out_sat_b;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        s;
    int          due;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] xs[3], ws[3], bs[3], ed[3];
  bit es[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_conv_channel_p #(.DATA_W(16), .FRAC_W(8), .ACC_W(40), .CH(2), .KW(2), .KH(2), .OUT_COLS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid_a),
    .in_data(in_data), .weight(weight), .bias(bias),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a), .out_sat(out_sat_a));

  sr_conv_channel_p #(.DATA_W(16), .FRAC_W(8), .ACC_W(40), .CH(2), .KW(2), .KH(2), .OUT_COLS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid_b),
    .in_data(in_data), .weight(weight), .bias(bias),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b), .out_sat(out_sat_b));

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic setcol(input int c, input logic [15:0] x, input logic [15:0] w,
                        input logic [15:0] b, input logic [15:0] e, input bit s);
    xs[c] = x; ws[c] = w; bs[c] = b; ed[c] = e; es[c] = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
    end
  endtask

  // Beats in order row, col, tap, ch; expectation pushed on each final beat.
  task automatic send(input bit sel, input int nbeats, input int gap,
                      input bit all_beats, input bit push);
    int ncols = sel ? 1 : 3;
    int n = 0;
    exp_t e;
    for (int row = 0; row < 2; row++)
      for (int col = 0; col < ncols; col++)
        for (int tap = 0; tap < 2; tap++)
          for (int ch = 0; ch < 2; ch++) begin
            bit hot;
            if (n < nbeats) begin
              while ($urandom_range(99, 0) < gap) begin
                @(negedge clk);
                in_valid_a = 1'b0;
                in_valid_b = 1'b0;
              end
              @(negedge clk);
              hot = all_beats || (row == 0 && tap == 0 && ch == 0);
              in_data = hot ? xs[col] : '0;
              weight  = hot ? ws[col] : '0;
              bias    = bs[col];
              in_valid_a = !sel;
              in_valid_b = sel;
              if (push && row == 1 && tap == 1 && ch == 1) begin
                e.d = ed[col];
                e.l = (col == ncols - 1);
                e.s = es[col];
                e.due = cyc + 4;
                if (sel) q_b.push_back(e);
                else q_a.push_back(e);
              end
              n++;
            end
          end
  endtask

  task automatic set_unity();
    for (int c = 0; c < 3; c++) setcol(c, 16'h0100, 16'h0100, 16'h0000, 16'h0800, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a) begin
      if (q_a.size() == 0) chk("a_spurious_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_data", int'({16'h0, out_data_a}), int'({16'h0, e.d}));
        chk("a_last", int'(out_last_a), int'(e.l));
        chk("a_sat", int'(out_sat_a), int'(e.s));
        chk("a_latency", cyc, e.due);
      end
    end else begin
      chk("a_idle_flags", int'({out_last_a, out_sat_a}), 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid_b) begin
      if (q_b.size() == 0) chk("b_spurious_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_data", int'({16'h0, out_data_b}), int'({16'h0, e.d}));
        chk("b_last", int'(out_last_b), int'(e.l));
        chk("b_sat", int'(out_sat_b), int'(e.s));
        chk("b_latency", cyc, e.due);
      end
    end else begin
      chk("b_idle_flags", int'({out_last_b, out_sat_b}), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_data", int'({16'h0, out_data_a}), 0);
    chk("reset_out_valid", int'(out_valid_a), 0);
    chk("reset_out_last", int'(out_last_a), 0);
    chk("reset_out_sat", int'(out_sat_a), 0);
    chk("reset_b_out_data", int'({16'h0, out_data_b}), 0);
    rst_n = 1'b1;
    idle(2);

    // unity: 8 products of 1.0 per output
    set_unity();
    send(0, 24, 0, 1, 1);
    idle(6);

    // rounding, one nonzero product per output in kernel row 0
    setcol(0, 16'h0001, 16'h0080, 16'h0000, 16'h0000, 1'b0);
    setcol(1, 16'h0001, 16'h0080, 16'h0001, 16'h0002, 1'b0);
    setcol(2, 16'h0001, 16'h0180, 16'h0000, 16'h0002, 1'b0);
    send(0, 24, 0, 0, 1);
    setcol(0, 16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 1'b0);
    setcol(1, 16'h0001, 16'h00C0, 16'h0000, 16'h0001, 1'b0);
    setcol(2, 16'hFFFF, 16'h0180, 16'h0000, 16'hFFFE, 1'b0);
    send(0, 24, 0, 0, 1);
    idle(6);

    // saturation both ways, plus a negative sum with a half-LSB-scaled bias
    setcol(0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
    setcol(1, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 1'b1);
    setcol(2, 16'h0100, 16'hFF00, 16'h0080, 16'hF880, 1'b0);
    send(0, 24, 0, 1, 1);
    idle(6);

    // gaps in in_valid, then the single-column instance
    set_unity();
    send(0, 24, 30, 1, 1);
    idle(6);
    send(1, 16, 0, 1, 1);
    send(1, 16, 30, 1, 1);
    send(1, 16, 0, 1, 1);
    idle(6);

    // clear in kernel row 1 with the last result still in flight
    send(0, 16, 0, 1, 0);
    @(negedge clk);
    clear = 1'b1;
    in_valid_a = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid_a = 1'b0;
    send(0, 24, 0, 1, 1);
    idle(6);

    // asynchronous reset during kernel row 1
    send(0, 16, 0, 1, 0);
    @(negedge clk);
    in_valid_a = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", int'({16'h0, out_data_a}), 0);
    chk("midrst_out_valid", int'(out_valid_a), 0);
    chk("midrst_out_last", int'(out_last_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    send(0, 24, 0, 1, 1);
    idle(1);

    for (int i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    idle(8);
    chk("a_results_missing", q_a.size(), 0);
    chk("b_results_missing", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
